// File: rtl/load_align_extender_if.sv
// Load aligner request/response bundle: request side flows in, result side flows out.
interface load_align_extender_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 5
);
  localparam int unsigned OFF_W = $clog2(DATA_WIDTH / 8);

  logic                  i_Valid;
  logic                  o_Ready;
  logic [DATA_WIDTH-1:0] i_Data;
  logic [OFF_W-1:0]      i_Offset;
  logic [1:0]            i_Size;
  logic                  i_ExtensionType;
  logic [TAG_WIDTH-1:0]  i_Tag;
  logic                  o_Valid;
  logic                  i_Ready;
  logic [DATA_WIDTH-1:0] o_Q;
  logic [TAG_WIDTH-1:0]  o_Tag;
  logic                  o_Fault;

  // Aligner side.
  modport slave (
    input  i_Valid, i_Data, i_Offset, i_Size, i_ExtensionType, i_Tag, i_Ready,
    output o_Ready, o_Valid, o_Q, o_Tag, o_Fault
  );

  // Memory-stage / writeback side.
  modport master (
    output i_Valid, i_Data, i_Offset, i_Size, i_ExtensionType, i_Tag, i_Ready,
    input  o_Ready, o_Valid, o_Q, o_Tag, o_Fault
  );
endinterface

// File: rtl/load_align_extender.sv
// Load-data aligner/extender with one registered output stage and a skid buffer.
module load_align_extender #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 5
) (
  input logic                  i_CLK,
  input logic                  i_RSTn,
  load_align_extender_if.slave bus
);
  localparam int unsigned OFF_W = $clog2(DATA_WIDTH / 8);
  localparam int unsigned SHW   = OFF_W + 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] q;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  fault;
  } entry_t;

  state_e state_q, state_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   valid_q, valid_d;
  logic   ready_q, ready_d;

  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] extended;
  logic                  sign_bit;
  logic                  misaligned;
  logic                  unsupported;
  logic                  fault;
  entry_t                new_entry;
  logic                  in_xfer;
  logic                  out_xfer;

  // Bring the addressed byte to bit 0.
  assign shamt   = {bus.i_Offset, 3'b000};
  assign shifted = bus.i_Data >> shamt;

  // Field mask, field MSB and alignment check per access size.
  always_comb begin
    mask       = '0;
    sign_bit   = 1'b0;
    misaligned = 1'b0;
    case (bus.i_Size)
      2'd0: begin
        mask     = DATA_WIDTH'(8'hFF);
        sign_bit = shifted[7];
      end
      2'd1: begin
        mask       = DATA_WIDTH'(16'hFFFF);
        sign_bit   = shifted[15];
        misaligned = bus.i_Offset[0];
      end
      2'd2: begin
        mask       = DATA_WIDTH'(32'hFFFF_FFFF);
        sign_bit   = shifted[31];
        misaligned = |bus.i_Offset[1:0];
      end
      default: begin
        mask       = '1;
        sign_bit   = shifted[DATA_WIDTH-1];
        misaligned = |bus.i_Offset;
      end
    endcase
  end

  // Faulting loads return zero but keep their tag so writeback can retire them.
  assign unsupported = (bus.i_Size == 2'd3) && (DATA_WIDTH == 32);
  assign fault       = misaligned | unsupported;
  assign extended    = fault ? '0
                     : ((shifted & mask) | ((sign_bit & bus.i_ExtensionType) ? ~mask : '0));

  assign new_entry.q     = extended;
  assign new_entry.tag   = bus.i_Tag;
  assign new_entry.fault = fault;

  assign in_xfer  = bus.i_Valid & ready_q;
  assign out_xfer = valid_q & bus.i_Ready;

  // Next-state and storage steering for the output/skid pair.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          out_d   = new_entry;
        end
      end
      ONE: begin
        case ({in_xfer, out_xfer})
          2'b10: begin
            state_d = FULL;
            skid_d  = new_entry;
          end
          2'b01: state_d = EMPTY;
          2'b11: out_d = new_entry;
          default: state_d = ONE;
        endcase
      end
      FULL: begin
        if (out_xfer) begin
          state_d = ONE;
          out_d   = skid_q;
          skid_d  = '0;
        end
      end
      default: state_d = EMPTY;
    endcase
    valid_d = (state_d != EMPTY);
    ready_d = (state_d != FULL);
  end

  // State, handshake flops and payload registers.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign bus.o_Valid = valid_q;
  assign bus.o_Ready = ready_q;
  assign bus.o_Q     = out_q.q;
  assign bus.o_Tag   = out_q.tag;
  assign bus.o_Fault = out_q.fault;

endmodule

// File: tb/tb_load_align_extender.sv
// Scoreboard bench for load_align_extender at 32- and 64-bit data widths.
module tb_load_align_extender;
  localparam int unsigned TW = 5;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  load_align_extender_if #(.DATA_WIDTH(32), .TAG_WIDTH(TW)) if32();
  load_align_extender_if #(.DATA_WIDTH(64), .TAG_WIDTH(TW)) if64();

  load_align_extender #(.DATA_WIDTH(32), .TAG_WIDTH(TW)) dut32 (
    .i_CLK (clk),
    .i_RSTn(rst_n),
    .bus   (if32.slave)
  );

  load_align_extender #(.DATA_WIDTH(64), .TAG_WIDTH(TW)) dut64 (
    .i_CLK (clk),
    .i_RSTn(rst_n),
    .bus   (if64.slave)
  );

  typedef struct {
    logic [63:0]   q;
    logic [TW-1:0] tag;
    logic          fault;
  } exp_t;

  exp_t sb32[$];
  exp_t sb64[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent byte-loop reference for the random traffic.
  function automatic void model(input int dw, input logic [63:0] d, input int off,
                                input int size, input bit ext,
                                output logic [63:0] q, output bit f);
    int          s;
    logic [63:0] fld;
    bit          sg;
    s   = 1 << size;
    fld = '0;
    f   = ((off % s) != 0) || (size == 3 && dw == 32);
    q   = '0;
    if (!f) begin
      for (int b = 0; b < s; b++) fld[8*b +: 8] = d[8*(off+b) +: 8];
      sg = ext && fld[8*s-1];
      q  = fld;
      for (int i = 8 * s; i < dw; i++) q[i] = sg;
    end
  endfunction

  // Result monitor, 32-bit instance: compares whatever is presented, pops on transfer.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && if32.o_Valid === 1'b1) begin
      if (sb32.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out32_unexpected: got tag %0d q %h, expected no output", if32.o_Tag, if32.o_Q);
      end else begin
        check("out32_q", 64'(if32.o_Q), sb32[0].q);
        check("out32_tag", 64'(if32.o_Tag), 64'(sb32[0].tag));
        check("out32_fault", 64'(if32.o_Fault), 64'(sb32[0].fault));
        if (if32.i_Ready) void'(sb32.pop_front());
      end
    end
  end

  // Result monitor, 64-bit instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && if64.o_Valid === 1'b1) begin
      if (sb64.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out64_unexpected: got tag %0d q %h, expected no output", if64.o_Tag, if64.o_Q);
      end else begin
        check("out64_q", if64.o_Q, sb64[0].q);
        check("out64_tag", 64'(if64.o_Tag), 64'(sb64[0].tag));
        check("out64_fault", 64'(if64.o_Fault), 64'(sb64[0].fault));
        if (if64.i_Ready) void'(sb64.pop_front());
      end
    end
  end

  // Issue one request (called at posedge+1); expectation is queued at the accepting edge.
  task automatic send(input bit w64, input logic [63:0] data, input int off, input int size,
                      input bit ext, input int tag, input logic [63:0] eq, input bit ef,
                      output int waits);
    bit   acc;
    exp_t e;
    acc     = 1'b0;
    waits   = 0;
    e.q     = eq;
    e.tag   = TW'(tag);
    e.fault = ef;
    if (w64) begin
      if64.i_Valid = 1'b1; if64.i_Data = data; if64.i_Offset = 3'(off);
      if64.i_Size = 2'(size); if64.i_ExtensionType = ext; if64.i_Tag = TW'(tag);
    end else begin
      if32.i_Valid = 1'b1; if32.i_Data = data[31:0]; if32.i_Offset = 2'(off);
      if32.i_Size = 2'(size); if32.i_ExtensionType = ext; if32.i_Tag = TW'(tag);
    end
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      if (w64 ? if64.o_Ready : if32.o_Ready) begin
        acc = 1'b1;
        if (w64) sb64.push_back(e);
        else     sb32.push_back(e);
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (w64) if64.i_Valid = 1'b0;
    else     if32.i_Valid = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: tag %0d not accepted, required within 50 cycles", tag);
    end
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && (sb32.size() != 0 || sb64.size() != 0); c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int          w;
    int          stalls;
    int          vcount;
    int          sz;
    int          off;
    bit          ext;
    bit          f;
    logic [63:0] d;
    logic [63:0] q;

    rst_n = 1'b1;
    if32.i_Valid = 1'b0; if32.i_Data = '0; if32.i_Offset = '0; if32.i_Size = '0;
    if32.i_ExtensionType = 1'b0; if32.i_Tag = '0; if32.i_Ready = 1'b1;
    if64.i_Valid = 1'b0; if64.i_Data = '0; if64.i_Offset = '0; if64.i_Size = '0;
    if64.i_ExtensionType = 1'b0; if64.i_Tag = '0; if64.i_Ready = 1'b1;

    // Power-on reset values.
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(if32.o_Valid), 64'd0);
    check("rst_ready", 64'(if32.o_Ready), 64'd1);
    check("rst_q", 64'(if32.o_Q), 64'd0);
    check("rst_tag", 64'(if32.o_Tag), 64'd0);
    check("rst_fault", 64'(if32.o_Fault), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed 32-bit vectors.
    send(0, 64'h80FF7F01, 3, 0, 1, 1, 64'hFFFFFF80, 0, w);
    send(0, 64'h80FF7F01, 3, 0, 0, 2, 64'h00000080, 0, w);
    send(0, 64'h80FF7F01, 1, 0, 1, 3, 64'h0000007F, 0, w);
    send(0, 64'h80FF7F01, 2, 0, 1, 4, 64'hFFFFFFFF, 0, w);
    send(0, 64'h80017FFE, 2, 1, 1, 5, 64'hFFFF8001, 0, w);
    send(0, 64'h80017FFE, 0, 1, 0, 6, 64'h00007FFE, 0, w);
    send(0, 64'h80017FFE, 1, 1, 1, 7, 64'h0, 1, w);
    send(0, 64'h80FF7F01, 0, 3, 0, 8, 64'h0, 1, w);
    send(0, 64'h80FF7F01, 0, 2, 1, 9, 64'h80FF7F01, 0, w);
    send(0, 64'h80FF7F01, 2, 2, 0, 10, 64'h0, 1, w);
    drain(20);

    // Back-pressure: two accepted, third held until the consumer frees space.
    if32.i_Ready = 1'b0;
    send(0, 64'h11223344, 0, 2, 0, 1, 64'h11223344, 0, w);
    send(0, 64'h11223344, 1, 0, 0, 2, 64'h00000033, 0, w);
    check("bp_ready_low", 64'(if32.o_Ready), 64'd0);
    fork
      send(0, 64'h11223344, 2, 1, 0, 3, 64'h00001122, 0, w);
      begin
        repeat (4) @(posedge clk);
        #1;
        check("bp_ready_held", 64'(if32.o_Ready), 64'd0);
        if32.i_Ready = 1'b1;
      end
    join
    check("bp_tag3_waited", 64'(w > 0), 64'd1);
    drain(20);
    check("bp_drained", 64'(sb32.size()), 64'd0);

    // Full throughput: 16 random legal requests, never stalled.
    stalls = 0;
    for (int n = 0; n < 16; n++) begin
      sz  = int'($urandom_range(0, 2));
      off = int'($urandom_range(0, (4 >> sz) - 1)) << sz;
      ext = 1'($urandom_range(0, 1));
      d   = {32'h0, $urandom()};
      model(32, d, off, sz, ext, q, f);
      send(0, d, off, sz, ext, n + 11, q, f, w);
      stalls += w;
    end
    check("tput_no_stall", 64'(stalls), 64'd0);
    drain(20);

    // 64-bit instance.
    send(1, 64'h8123456789ABCDEF, 0, 3, 1, 1, 64'h8123456789ABCDEF, 0, w);
    send(1, 64'h8123456789ABCDEF, 4, 2, 1, 2, 64'hFFFFFFFF81234567, 0, w);
    send(1, 64'h8123456789ABCDEF, 0, 2, 0, 3, 64'h0000000089ABCDEF, 0, w);
    send(1, 64'h8123456789ABCDEF, 6, 1, 0, 4, 64'h0000000000008123, 0, w);
    send(1, 64'h8123456789ABCDEF, 7, 0, 1, 5, 64'hFFFFFFFFFFFFFF81, 0, w);
    send(1, 64'h8123456789ABCDEF, 4, 3, 0, 6, 64'h0, 1, w);
    drain(20);

    // Reset while FULL: everything in flight is dropped.
    if32.i_Ready = 1'b0;
    send(0, 64'hCAFEBABE, 0, 2, 0, 20, 64'hCAFEBABE, 0, w);
    send(0, 64'hCAFEBABE, 1, 0, 0, 21, 64'h000000BA, 0, w);
    check("pre_rst_full", 64'(if32.o_Ready), 64'd0);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(if32.o_Valid), 64'd0);
    check("midrst_ready", 64'(if32.o_Ready), 64'd1);
    check("midrst_q", 64'(if32.o_Q), 64'd0);
    sb32.delete();
    #2 rst_n = 1'b1;
    if32.i_Ready = 1'b1;
    vcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (if32.o_Valid) vcount++;
    end
    check("midrst_no_stale", 64'(vcount), 64'd0);
    @(posedge clk);
    #1;
    send(0, 64'h0000F000, 1, 0, 1, 22, 64'hFFFFFFF0, 0, w);
    drain(20);
    check("final_empty32", 64'(sb32.size()), 64'd0);
    check("final_empty64", 64'(sb64.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_align_extender.md
# load_align_extender

Pipelined load-data aligner and extender for the haze-cpu memory stage. It takes a raw memory word, the load's byte offset, size and signedness. It selects the addressed byte, halfword, word or doubleword and zero- or sign-extends it to the full data width. Results pass through one registered stage with a valid/ready handshake and a skid buffer, so back-pressure from writeback never drops a load. It sits between the data-memory read port and the writeback mux and replaces the combinational N-to-M extender on the load path.

## Interface
- DATA_WIDTH, 32, memory word and result width in bits; 32 or 64 only.
- TAG_WIDTH, 5, width of the sideband tag (destination register index) carried alongside each load.
- i_CLK  in  1  clock, all state on rising edge.
- i_RSTn  in  1  asynchronous active-low reset.
- i_Valid  in  1  input request valid.
- o_Ready  out  1  block can accept a request this cycle.
- i_Data  in  DATA_WIDTH  raw memory word as read.
- i_Offset  in  $clog2(DATA_WIDTH/8)  byte offset of the load within i_Data; byte 0 is i_Data[7:0].
- i_Size  in  2  0 byte, 1 halfword, 2 word, 3 doubleword.
- i_ExtensionType  in  1  0 zero-extend, 1 sign-extend.
- i_Tag  in  TAG_WIDTH  sideband, returned unchanged.
- o_Valid  out  1  result valid.
- i_Ready  in  1  consumer accepts the result.
- o_Q  out  DATA_WIDTH  aligned, extended result.
- o_Tag  out  TAG_WIDTH  tag of the result.
- o_Fault  out  1  the request was misaligned or used an unsupported size.

## Operation
- The input transfer occurs when i_Valid && o_Ready. The output transfer occurs when o_Valid && i_Ready.
- Size in bytes is S = 1 << i_Size. The extracted field is i_Data[8*i_Offset +: 8*S].
- Extension rules:
  - Zero-extension fills the upper bits with 0.
  - Sign-extension replicates the field MSB.
  - A full-width field is passed through unchanged.
- Fault conditions:
  - Misaligned when i_Offset mod S != 0.
  - Unsupported when i_Size == 3 and DATA_WIDTH == 32.
  - On a fault, o_Q = 0, o_Fault = 1 and the tag is still returned.
  - A fault never blocks the pipe.
- Storage is one output register plus one skid register. Each holds {Q, Tag, Fault, valid}.
- States:
  - EMPTY: o_Valid = 0, o_Ready = 1.
  - ONE: the output register holds data, o_Valid = 1, o_Ready = 1.
  - FULL: both registers hold data, o_Valid = 1, o_Ready = 0.
- Transitions:
  - EMPTY: an input transfer moves to ONE.
  - ONE, input only: moves to FULL, and the new entry goes to skid.
  - ONE, output only: moves to EMPTY.
  - ONE, both: stays in ONE, and the output register loads the new entry.
  - FULL, output transfer: skid moves into the output register and the state becomes ONE. No input is possible because o_Ready = 0.
- o_Ready is driven directly from a flop (not skid-full). It has no combinational path from i_Ready.
- Order is strictly FIFO; no reordering.
- o_Q, o_Tag and o_Fault hold stable while o_Valid && !i_Ready.

## Timing
- Reset values, asynchronous on the i_RSTn falling edge:
  - State EMPTY, o_Valid = 0, o_Ready = 1.
  - o_Q = 0, o_Tag = 0, o_Fault = 0.
  - Skid register cleared.
- Latency: a request accepted at edge k is presented on o_Valid/o_Q immediately after edge k, i.e. one cycle.
- Throughput: one result per cycle while i_Ready = 1.
- Stall: with i_Ready = 0, at most 2 requests are accepted. o_Ready drops in the cycle after the second acceptance.
- Recovery: o_Ready returns to 1 in the cycle after the output transfer that empties skid.
- Reset mid-operation: all in-flight entries are discarded without any output transfer.
- No X propagation: when i_Valid = 0, i_Data, i_Offset and i_Size are ignored and state is unchanged.

## Test plan
- **Byte sign-extend, DATA_WIDTH = 32.**
  - Stimulus: i_Data = 0x80FF7F01, i_Offset = 3, i_Size = 0, i_ExtensionType = 1.
  - Response: o_Q = 0xFFFFFF80, o_Fault = 0, one cycle later.
  - Repeat with i_ExtensionType = 0: o_Q = 0x00000080.
- **Halfword.**
  - Stimulus: i_Data = 0x8001_7FFE, offset 2, sign-extend.
  - Response: o_Q = 0xFFFF8001.
  - Offset 0, zero-extend: o_Q = 0x00007FFE.
- **Faults.**
  - Stimulus: halfword at offset 1, tag 7.
  - Response: o_Q = 0, o_Fault = 1, o_Tag = 7.
  - Size 3 on DATA_WIDTH = 32 also gives o_Fault = 1.
  - DATA_WIDTH = 64, dword at offset 0: o_Q equals i_Data.
- **Back-pressure.**
  - Stimulus: hold i_Ready = 0 and stream tags 1, 2, 3 with i_Valid = 1.
  - Response: tags 1 and 2 are accepted. o_Ready = 0 from the cycle after tag 2's acceptance, and tag 3 is held.
  - Then raise i_Ready: outputs appear in order 1, 2, 3 with no loss or duplication, and o_Q holds stable while stalled.
- **Full throughput.**
  - Stimulus: i_Ready = 1, 16 back-to-back random legal requests.
  - Response: 16 consecutive o_Valid cycles matching a reference model, o_Ready constantly 1.
- **Reset mid-operation.**
  - Stimulus: reach FULL, then pulse i_RSTn low asynchronously between edges.
  - Response: o_Valid = 0, o_Ready = 1, o_Q = 0 immediately. No stale result appears after release.
